issue_ctrl: RTL and testbench

//  Issue-stage scheduler between fetch and the decode/dispatch path of the Tomasulo core.

---
 rtl/issue_pkg.sv | 48 ++++
 rtl/issue_iq.sv | 75 +++++++
 rtl/issue_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
//   Shared constants for the issue stage: RISC-V major opcodes, the reserved
//   "no tag" ROB index, the dispatch class encoding and the issue FSM state
//   encoding. Also holds the opcode -> class predecode helper.
// -----------------------------------------------------------------------------
package issue_pkg;

    localparam int ROB_IDX_W_DEF = 4;
    localparam int ZERO_ROB      = 0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        CLS_NOP = 2'd0,
        CLS_RS  = 2'd1,
        CLS_LSB = 2'd2
    } cls_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_DISPATCH = 2'd2,
        S_FLUSH    = 2'd3
    } state_e;

    // Loads/stores go to the LSB, every other recognised opcode to the RS;
    // unrecognised opcodes are dropped as NOPs without consuming a ROB tag.
    function automatic cls_e classify(input logic [6:0] op);
        cls_e cls;
        case (op)
            OP_LOAD, OP_STORE:                   cls = CLS_LSB;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_BRANCH, OP_IMM, OP_REG:           cls = CLS_RS;
            default:                             cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/issue_iq.sv
// -----------------------------------------------------------------------------
// issue_iq
//   Instruction queue: circular buffer of {inst, pc} with read/write pointers
//   carrying one extra wrap bit so full and empty are distinguishable.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clear_i                drop all entries (flush); wins over push/pop
//   push_i                 write push_inst_i/push_pc_i at the tail
//   pop_i                  retire the head entry
//   full_o, empty_o        occupancy flags
//   count_o                number of stored entries
//   head_inst_o, head_pc_o head entry contents (valid when !empty_o)
// -----------------------------------------------------------------------------
module issue_iq #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [31:0]                push_inst_i,
    input  logic [31:0]                push_pc_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [31:0]                head_inst_o,
    output logic [31:0]                head_pc_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [31:0]  inst_mem [DEPTH];
    logic [31:0]  pc_mem   [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            inst_mem[wptr_q[AW-1:0]] <= push_inst_i;
            pc_mem[wptr_q[AW-1:0]]   <= push_pc_i;
        end
    end

    assign empty_o     = (wptr_q == rptr_q);
    assign full_o      = (wptr_q[AW] != rptr_q[AW]) &&
                         (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o     = wptr_q - rptr_q;
    assign head_inst_o = inst_mem[rptr_q[AW-1:0]];
    assign head_pc_o   = pc_mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//   Issue-stage scheduler between fetch and decode/dispatch. Buffers fetched
//   instructions in issue_iq, issues at most one instruction every two cycles
//   (ISSUE: dec_ena + ROB tag allocation, DISPATCH: to_rs/to_lsb strobe),
//   stalls while the ROB or the target station is full, and on a mispredict
//   flush drains the queue and re-bases tag allocation at flush_tag.
//
// Handshake: fetch offers with if_valid; an instruction is taken on every
//   rising edge where if_valid && if_ready. if_ready depends only on queue
//   fullness and flush, never on if_valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_valid/if_inst/if_pc      fetch offer;   if_ready: queue can accept
//   dec_ena                     one-cycle decode enable (ISSUE cycle)
//   dec_inst/dec_pc/dec_tag     issued instruction, PC and ROB tag (0 = none)
//   rob_full/rs_full/lsb_full   back-pressure from ROB / RS / LSB
//   to_rs/to_lsb                dispatch strobes (DISPATCH cycle)
//   flush/flush_tag             mispredict flush and next tag to allocate
//   dbg_state                   current FSM state (issue_pkg::state_e)
//   perf_issued/perf_stall      saturating event counters (ISSUE_PERF_EN only)
//
// Configuration: define ISSUE_PERF_EN to add the perf_issued/perf_stall
//   counters and ports; without it the counters and ports do not exist.
// -----------------------------------------------------------------------------
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int IQ_DEPTH  = 4,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_valid,
    input  logic [31:0]          if_inst,
    input  logic [31:0]          if_pc,
    output logic                 if_ready,
    output logic                 dec_ena,
    output logic [31:0]          dec_inst,
    output logic [31:0]          dec_pc,
    output logic [ROB_IDX_W-1:0] dec_tag,
    input  logic                 rob_full,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    output logic                 to_rs,
    output logic                 to_lsb,
    input  logic                 flush,
    input  logic [ROB_IDX_W-1:0] flush_tag,
`ifdef ISSUE_PERF_EN
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall,
`endif
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ROB_IDX_W-1:0]  tail_q, tail_d;
    logic [ROB_IDX_W-1:0]  dec_tag_q, dec_tag_d;
    logic [31:0]           dec_inst_q, dec_inst_d;
    logic [31:0]           dec_pc_q, dec_pc_d;
    cls_e                  cls_q, cls_d;

    logic                  iq_push, iq_pop, iq_full, iq_empty;
    logic [CW-1:0]         iq_count;
    logic [31:0]           head_inst, head_pc;
    cls_e                  head_cls;
    logic                  target_full, can_issue, stall;
    logic [ROB_IDX_W-1:0]  tail_next;

    // Push is accepted only when not full and not flushing; a push coinciding
    // with a flush is dropped together with the rest of the queue.
    assign if_ready = !iq_full && !flush && (state_q != S_FLUSH);
    assign iq_push  = if_valid && if_ready;

    issue_iq #(.DEPTH(IQ_DEPTH)) u_iq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .push_i      (iq_push),
        .push_inst_i (if_inst),
        .push_pc_i   (if_pc),
        .pop_i       (iq_pop),
        .full_o      (iq_full),
        .empty_o     (iq_empty),
        .count_o     (iq_count),
        .head_inst_o (head_inst),
        .head_pc_o   (head_pc)
    );

    assign head_cls    = classify(head_inst[6:0]);
    assign target_full = (head_cls == CLS_LSB) ? lsb_full : rs_full;
    assign can_issue   = !iq_empty && (head_cls != CLS_NOP) && !rob_full && !target_full;

    // Tag 0 is reserved as "no tag", so allocation wraps from all-ones to 1.
    assign tail_next = (tail_q == '1) ? ROB_IDX_W'(1) : tail_q + ROB_IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        dec_tag_d  = dec_tag_q;
        dec_inst_d = dec_inst_q;
        dec_pc_d   = dec_pc_q;
        cls_d      = cls_q;
        iq_pop     = 1'b0;
        dec_ena    = 1'b0;
        to_rs      = 1'b0;
        to_lsb     = 1'b0;
        stall      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!iq_empty) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (iq_empty) begin
                    state_d = S_IDLE;
                end else if (head_cls == CLS_NOP) begin
                    // Drop the NOP; stay only if something remains after the pop.
                    iq_pop  = 1'b1;
                    state_d = ((iq_count > CW'(1)) || iq_push) ? S_ISSUE : S_IDLE;
                end else if (can_issue) begin
                    dec_ena    = 1'b1;
                    iq_pop     = 1'b1;
                    dec_inst_d = head_inst;
                    dec_pc_d   = head_pc;
                    dec_tag_d  = tail_q;
                    tail_d     = tail_next;
                    cls_d      = head_cls;
                    state_d    = S_DISPATCH;
                end else begin
                    stall = 1'b1;
                end
            end
            S_DISPATCH: begin
                // Resources were reserved in ISSUE; full inputs are ignored here.
                to_rs     = (cls_q == CLS_RS);
                to_lsb    = (cls_q == CLS_LSB);
                dec_tag_d = ROB_IDX_W'(ZERO_ROB);
                state_d   = iq_empty ? S_IDLE : S_ISSUE;
            end
            S_FLUSH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides every decision taken above.
        if (flush) begin
            state_d   = S_FLUSH;
            tail_d    = flush_tag;
            dec_tag_d = ROB_IDX_W'(ZERO_ROB);
            iq_pop    = 1'b0;
            dec_ena   = 1'b0;
            to_rs     = 1'b0;
            to_lsb    = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tail_q     <= ROB_IDX_W'(1);
            dec_tag_q  <= ROB_IDX_W'(ZERO_ROB);
            dec_inst_q <= '0;
            dec_pc_q   <= '0;
            cls_q      <= CLS_NOP;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            dec_tag_q  <= dec_tag_d;
            dec_inst_q <= dec_inst_d;
            dec_pc_q   <= dec_pc_d;
            cls_q      <= cls_d;
        end
    end

    assign dec_inst  = dec_inst_q;
    assign dec_pc    = dec_pc_q;
    assign dec_tag   = dec_tag_q;
    assign dbg_state = state_q;

`ifdef ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if ((to_rs || to_lsb) && (perf_issued_q != '1))
                perf_issued_q <= perf_issued_q + 32'd1;
            if (stall && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`else
    // Stall detection only feeds the perf counters.
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
//   Self-checking bench for issue_ctrl: a per-cycle vector table for the basic
//   issue/dispatch flow, plus directed sequences for stall, queue-full, tag
//   wrap, flush and mid-operation reset.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1 time unit later.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;
    import issue_pkg::*;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h00002083;
    localparam logic [31:0] I_SW   = 32'h00102023;
    localparam logic [31:0] I_NOP  = 32'h0000000F;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_valid = 1'b0;
    logic [31:0] if_inst = '0;
    logic [31:0] if_pc = '0;
    logic        if_ready;
    logic        dec_ena;
    logic [31:0] dec_inst, dec_pc;
    logic [3:0]  dec_tag;
    logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
    logic        to_rs, to_lsb;
    logic        flush = 1'b0;
    logic [3:0]  flush_tag = 4'd1;
    logic [1:0]  dbg_state;
`ifdef ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    issue_ctrl #(.IQ_DEPTH(4), .ROB_IDX_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .if_ready  (if_ready),
        .dec_ena   (dec_ena),
        .dec_inst  (dec_inst),
        .dec_pc    (dec_pc),
        .dec_tag   (dec_tag),
        .rob_full  (rob_full),
        .rs_full   (rs_full),
        .lsb_full  (lsb_full),
        .to_rs     (to_rs),
        .to_lsb    (to_lsb),
        .flush     (flush),
        .flush_tag (flush_tag),
`ifdef ISSUE_PERF_EN
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  exp_tag_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        if_valid = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Push one instruction into an empty queue and wait for its dispatch strobe.
    task automatic issue_one(input logic [31:0] inst, input logic [31:0] pc,
                             output logic [3:0] tag, output bit ok);
        ok = 1'b0;
        tag = '0;
        if_valid = 1'b1; if_inst = inst; if_pc = pc;
        tick();
        if_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (to_rs || to_lsb) begin
                tag = dec_tag;
                ok = 1'b1;
            end
            tick();
            if (ok) break;
        end
    endtask

    // Compare each dispatch against the head of exp_q / exp_tag_q.
    task automatic drain(input string name, input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            #1;
            if (to_rs || to_lsb) begin
                check({name, "_inst"}, dec_inst, exp_q.pop_front());
                check({name, "_tag"}, 32'(dec_tag), 32'(exp_tag_q.pop_front()));
            end
            tick();
        end
        check({name, "_remaining"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (dbg_state == st) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_reached"}, 32'(seen), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        robf, rsf, lsbf;
        logic        e_ena, e_rs, e_lsb;
        logic [3:0]  e_tag;
        logic        e_ready;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(logic v, logic [31:0] inst, logic [31:0] pc,
                                logic robf, logic rsf, logic lsbf,
                                logic e_ena, logic e_rs, logic e_lsb, logic [3:0] e_tag,
                                logic e_ready, logic [31:0] e_inst, logic [31:0] e_pc);
        vec_t r;
        r.v = v; r.inst = inst; r.pc = pc;
        r.robf = robf; r.rsf = rsf; r.lsbf = lsbf;
        r.e_ena = e_ena; r.e_rs = e_rs; r.e_lsb = e_lsb; r.e_tag = e_tag;
        r.e_ready = e_ready; r.e_inst = e_inst; r.e_pc = e_pc;
        return r;
    endfunction

    vec_t vecs[18];

    initial begin
        logic [3:0] tag;
        bit         ok;
        int         cnt;

        //             v  inst    pc       rob rs lsb  ena rs lsb tag rdy  e_inst  e_pc
        vecs[0]  = mk(0, 0,      0,        0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // reset state
        vecs[1]  = mk(1, I_ADDI, 32'h100,  0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // push ADDI
        vecs[2]  = mk(0, 0,      0,        0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // IDLE -> ISSUE
        vecs[3]  = mk(0, 0,      0,        0, 0, 0,    1, 0, 0, 0,  1,   0,      0);       // ISSUE
        vecs[4]  = mk(0, 0,      0,        0, 0, 0,    0, 1, 0, 1,  1,   I_ADDI, 32'h100); // DISPATCH tag 1
        vecs[5]  = mk(1, I_LW,   32'h104,  0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // push LW
        vecs[6]  = mk(1, I_SW,   32'h108,  0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // push SW
        vecs[7]  = mk(0, 0,      0,        0, 0, 0,    1, 0, 0, 0,  1,   0,      0);       // issue LW
        vecs[8]  = mk(0, 0,      0,        0, 0, 0,    0, 0, 1, 2,  1,   I_LW,   32'h104);
        vecs[9]  = mk(0, 0,      0,        0, 0, 0,    1, 0, 0, 0,  1,   0,      0);       // issue SW
        vecs[10] = mk(0, 0,      0,        0, 0, 0,    0, 0, 1, 3,  1,   I_SW,   32'h108);
        vecs[11] = mk(1, I_NOP,  32'h10C,  0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // push NOP
        vecs[12] = mk(0, 0,      0,        0, 0, 0,    0, 0, 0, 0,  1,   0,      0);
        vecs[13] = mk(0, 0,      0,        0, 0, 0,    0, 0, 0, 0,  1,   0,      0);       // NOP popped
        vecs[14] = mk(1, I_ADDI, 32'h110,  0, 0, 0,    0, 0, 0, 0,  1,   0,      0);
        vecs[15] = mk(0, 0,      0,        0, 0, 0,    0, 0, 0, 0,  1,   0,      0);
        vecs[16] = mk(0, 0,      0,        0, 0, 1,    1, 0, 0, 0,  1,   0,      0);       // lsb_full does not block RS
        vecs[17] = mk(0, 0,      0,        0, 0, 0,    0, 1, 0, 4,  1,   I_ADDI, 32'h110); // NOP took no tag

        do_reset();
        for (int i = 0; i < 18; i++) begin
            if_valid = vecs[i].v; if_inst = vecs[i].inst; if_pc = vecs[i].pc;
            rob_full = vecs[i].robf; rs_full = vecs[i].rsf; lsb_full = vecs[i].lsbf;
            #1;
            check($sformatf("v%0d_dec_ena", i), 32'(dec_ena), 32'(vecs[i].e_ena));
            check($sformatf("v%0d_to_rs", i), 32'(to_rs), 32'(vecs[i].e_rs));
            check($sformatf("v%0d_to_lsb", i), 32'(to_lsb), 32'(vecs[i].e_lsb));
            check($sformatf("v%0d_dec_tag", i), 32'(dec_tag), 32'(vecs[i].e_tag));
            check($sformatf("v%0d_if_ready", i), 32'(if_ready), 32'(vecs[i].e_ready));
            if (vecs[i].e_rs || vecs[i].e_lsb) begin
                check($sformatf("v%0d_dec_inst", i), dec_inst, vecs[i].e_inst);
                check($sformatf("v%0d_dec_pc", i), dec_pc, vecs[i].e_pc);
            end
            tick();
        end
        if_valid = 1'b0; lsb_full = 1'b0;

        // ---- rob_full stall with two queued, then release ----
        do_reset();
        rob_full = 1'b1;
        if_valid = 1'b1; if_inst = I_ADDI; if_pc = 32'h200;
        tick();
        if_inst = 32'h00A00113; if_pc = 32'h204;
        tick();
        if_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (dec_ena || to_rs || to_lsb) cnt++;
            tick();
        end
        check("rob_stall_no_issue", 32'(cnt), 32'd0);
        #1;
        check("rob_stall_ready", 32'(if_ready), 32'd1);
`ifdef ISSUE_PERF_EN
        check("rob_stall_perf_nonzero", 32'(perf_stall != 0), 32'd1);
        check("rob_stall_perf_issued", perf_issued, 32'd0);
`endif
        rob_full = 1'b0;
        exp_q.push_back(I_ADDI);      exp_tag_q.push_back(4'd1);
        exp_q.push_back(32'h00A00113); exp_tag_q.push_back(4'd2);
        drain("rob_release", 20);

        // ---- fill queue while rs_full, extra push ignored, drain in order ----
        do_reset();
        rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_inst = 32'h00000013 | (32'(i + 1) << 20); if_pc = 32'h300 + 32'(4 * i);
            #1;
            check($sformatf("fill%0d_ready", i), 32'(if_ready), 32'd1);
            exp_q.push_back(if_inst); exp_tag_q.push_back(4'(i + 1));
            tick();
        end
        if_inst = 32'h00900013; if_pc = 32'h3F0;
        #1;
        check("full_ready_low", 32'(if_ready), 32'd0);
        tick();
        if_valid = 1'b0;
        rs_full = 1'b0;
        drain("full_drain", 30);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (to_rs || to_lsb) cnt++;
            tick();
        end
        check("full_extra_dropped", 32'(cnt), 32'd0);

        // ---- tag wrap: 16th allocation gets tag 1 ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue_one(I_ADDI, 32'h400 + 32'(4 * i), tag, ok);
            check($sformatf("wrap%0d_done", i), 32'(ok), 32'd1);
            check($sformatf("wrap%0d_tag", i), 32'(tag), (i < 15) ? 32'(i + 1) : 32'd1);
        end

        // ---- flush during DISPATCH ----
        do_reset();
        if_valid = 1'b1; if_inst = I_ADDI; if_pc = 32'h500;
        tick();
        if_inst = I_LW; if_pc = 32'h504;
        tick();
        if_valid = 1'b0;
        wait_state(2'(S_DISPATCH), "flush_dispatch");
        flush = 1'b1; flush_tag = 4'd7;
        if_valid = 1'b1; if_inst = I_SW; if_pc = 32'h508;
        #1;
        check("flush_cyc_to_rs", 32'(to_rs), 32'd0);
        check("flush_cyc_dec_ena", 32'(dec_ena), 32'd0);
        check("flush_cyc_ready", 32'(if_ready), 32'd0);
        tick();
        flush = 1'b0; if_valid = 1'b0;
        #1;
        check("flush_state", 32'(dbg_state), 32'(S_FLUSH));
        check("flush_next_strobes", 32'({dec_ena, to_rs, to_lsb}), 32'd0);
        check("flush_next_ready", 32'(if_ready), 32'd0);
        check("flush_next_tag", 32'(dec_tag), 32'd0);
        tick();
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (dec_ena || to_rs || to_lsb) cnt++;
            tick();
        end
        check("flush_iq_empty", 32'(cnt), 32'd0);
        issue_one(I_ADDI, 32'h600, tag, ok);
        check("flush_reissue_done", 32'(ok), 32'd1);
        check("flush_reissue_tag", 32'(tag), 32'd7);

        // ---- reset in the middle of a dispatch ----
        if_valid = 1'b1; if_inst = I_LW; if_pc = 32'h700;
        tick();
        if_valid = 1'b0;
        wait_state(2'(S_DISPATCH), "rst_dispatch");
        rst_n = 1'b0;
        #1;
        check("rst_mid_to_lsb", 32'(to_lsb), 32'd0);
        check("rst_mid_tag", 32'(dec_tag), 32'd0);
        check("rst_mid_inst", dec_inst, 32'd0);
        check("rst_mid_ready", 32'(if_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        issue_one(I_SW, 32'h800, tag, ok);
        check("rst_after_done", 32'(ok), 32'd1);
        check("rst_after_tag", 32'(tag), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
